ma_stbuf: RTL and testbench

Parametrised successor to the memory-access stage. It sits between the EX/MA pipeline register and the single-port memory controller and performs register writeback pass-through, loads with sign/zero extension, and buffered stores.
- Stores retire into an SB_DEPTH-entry FIFO store buffer and drain to memory in the background.
- Loads take priority over draining and are forwarded from the buffer when fully covered.
- A fence drains the buffer completely.

---
 rtl/ma_stbuf_pkg.sv | 45 ++++
 rtl/ma_sb_fifo.sv | 107 ++++++++++
 rtl/ma_stbuf.sv | 177 +++++++++++++++++
 tb/tb_ma_stbuf.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ma_stbuf_pkg.sv
// Shared definitions for the memory-access stage with store buffer:
// funct3 width codes, byte-mask and load-extension helpers, FSM state types.
package ma_stbuf_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        L_IDLE,
        L_WAIT,
        L_DONE
    } lsu_state_t;

    typedef enum logic {
        D_IDLE,
        D_BUSY
    } drain_state_t;

    // Bits [1:0] of funct3 select the size; signedness does not affect the mask.
    function automatic logic [3:0] byte_mask(input logic [2:0] width, input logic [1:0] lo);
        logic [3:0] base;
        case (width[1:0])
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << lo;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] width);
        logic [31:0] r;
        case (width)
            F3_B:    r = {{24{d[7]}}, d[7:0]};
            F3_H:    r = {{16{d[15]}}, d[15:0]};
            F3_BU:   r = {24'h0, d[7:0]};
            F3_HU:   r = {16'h0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ma_sb_fifo.sv
// Circular store buffer: head/tail/count bookkeeping plus per-entry overlap
// and cover flags against a query access, and youngest-match selection.
module ma_sb_fifo
    import ma_stbuf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       push,
    input  logic [31:0]                push_addr,
    input  logic [2:0]                 push_width,
    input  logic [31:0]                push_data,
    input  logic                       pop,
    input  logic [31:0]                q_addr,
    input  logic [3:0]                 q_mask,
    output logic                       full,
    output logic                       empty,
    output logic [31:0]                head_addr,
    output logic [2:0]                 head_width,
    output logic [31:0]                head_data,
    output logic [DEPTH-1:0]           match_vec,
    output logic [DEPTH-1:0]           cover_vec,
    output logic [$clog2(DEPTH)-1:0]   hit_slot,
    output logic [31:0]                hit_data,
    output logic [1:0]                 hit_lo
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   addr_q  [DEPTH];
    logic [2:0]    width_q [DEPTH];
    logic [31:0]   data_q  [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;

    logic do_push;
    logic do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = en && push && !full;
    assign do_pop  = en && pop && !empty;

    assign head_addr  = addr_q[head];
    assign head_width = width_q[head];
    assign head_data  = data_q[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[tail]  <= push_addr;
            width_q[tail] <= push_width;
            data_q[tail]  <= push_data;
        end
    end

    always_comb begin
        logic [AW-1:0] age;
        logic [AW-1:0] slot;
        logic [3:0]    em;
        logic          valid;
        age       = '0;
        slot      = '0;
        em        = '0;
        valid     = 1'b0;
        match_vec = '0;
        cover_vec = '0;
        hit_slot  = '0;
        hit_data  = '0;
        hit_lo    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age   = AW'(i) - head;
            valid = ({1'b0, age} < count);
            em    = byte_mask(width_q[i], addr_q[i][1:0]);
            match_vec[i] = valid && (addr_q[i][31:2] == q_addr[31:2]) && |(em & q_mask);
            cover_vec[i] = match_vec[i] && ((em & q_mask) == q_mask);
        end
        // Walk oldest to youngest so the last match seen is the youngest.
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot = head + AW'(k);
            if (match_vec[slot]) begin
                hit_slot = slot;
                hit_data = data_q[slot];
                hit_lo   = addr_q[slot][1:0];
            end
        end
    end

endmodule

// File: rtl/ma_stbuf.sv
// Memory-access stage with writeback pass-through, extended loads, a FIFO
// store buffer draining in the background, store-to-load forwarding and fence.
module ma_stbuf
    import ma_stbuf_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 4,
    parameter bit          FWD_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_we,
    input  logic [4:0]  in_waddr,
    input  logic [31:0] in_wdata,
    input  logic        in_mem_we,
    input  logic        in_mem_re,
    input  logic        in_fence,
    input  logic [2:0]  in_width,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_mem_wdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_width,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        stall_req
);

    localparam int unsigned AW = $clog2(SB_DEPTH);

    lsu_state_t   l_state;
    drain_state_t d_state;
    logic [31:0]  ld_data;

    logic          sb_full;
    logic          sb_empty;
    logic [31:0]   head_addr;
    logic [2:0]    head_width;
    logic [31:0]   head_data;
    logic [SB_DEPTH-1:0] match_vec;
    logic [SB_DEPTH-1:0] cover_vec;
    logic [AW-1:0] hit_slot;
    logic [31:0]   hit_data;
    logic [1:0]    hit_lo;

    logic        ld_overlap;
    logic        ld_fwd;
    logic        ld_miss;
    logic        issue_rd;
    logic        drain_start;
    logic        sb_push;
    logic        sb_pop;
    logic [1:0]  fwd_shift;
    logic [31:0] fwd_ext;

    assign ld_overlap  = |match_vec;
    assign ld_fwd      = FWD_EN && in_mem_re && ld_overlap && cover_vec[hit_slot];
    assign ld_miss     = in_mem_re && !ld_overlap;
    assign issue_rd    = (l_state == L_IDLE) && ld_miss && (d_state == D_IDLE);
    // A conflicting load must not block draining or it would wait forever.
    assign drain_start = !sb_empty && !ld_miss && (l_state == L_IDLE) && (d_state == D_IDLE);
    assign sb_push     = rdy && in_mem_we && !in_mem_re;
    assign sb_pop      = rdy && (d_state == D_BUSY) && mem_ack;
    assign fwd_shift   = in_addr[1:0] - hit_lo;
    assign fwd_ext     = load_ext(hit_data >> {fwd_shift, 3'b000}, in_width);

    ma_sb_fifo #(
        .DEPTH (SB_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .en         (rdy),
        .push       (sb_push),
        .push_addr  (in_addr),
        .push_width (in_width),
        .push_data  (in_mem_wdata),
        .pop        (sb_pop),
        .q_addr     (in_addr),
        .q_mask     (byte_mask(in_width, in_addr[1:0])),
        .full       (sb_full),
        .empty      (sb_empty),
        .head_addr  (head_addr),
        .head_width (head_width),
        .head_data  (head_data),
        .match_vec  (match_vec),
        .cover_vec  (cover_vec),
        .hit_slot   (hit_slot),
        .hit_data   (hit_data),
        .hit_lo     (hit_lo)
    );

    always_comb begin
        stall_req = 1'b0;
        if (in_mem_re) begin
            case (l_state)
                L_IDLE:  stall_req = !ld_fwd;
                L_WAIT:  stall_req = 1'b1;
                default: stall_req = 1'b0;
            endcase
        end else if (in_mem_we) begin
            stall_req = sb_full;
        end else if (in_fence) begin
            stall_req = !sb_empty || (d_state != D_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_state   <= L_IDLE;
            d_state   <= D_IDLE;
            ld_data   <= '0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_width <= '0;
            mem_wdata <= '0;
            wb_we     <= 1'b0;
            wb_waddr  <= '0;
            wb_wdata  <= '0;
        end else if (rdy) begin
            case (l_state)
                L_IDLE: if (issue_rd) l_state <= L_WAIT;
                L_WAIT: if (mem_ack) begin
                    ld_data <= load_ext(mem_rdata, in_width);
                    l_state <= L_DONE;
                end
                default: l_state <= L_IDLE;
            endcase

            case (d_state)
                D_IDLE:  if (drain_start) d_state <= D_BUSY;
                default: if (mem_ack) d_state <= D_IDLE;
            endcase

            if (issue_rd) begin
                mem_req   <= 1'b1;
                mem_wr    <= 1'b0;
                mem_addr  <= in_addr;
                mem_width <= in_width;
                mem_wdata <= '0;
            end else if (drain_start) begin
                mem_req   <= 1'b1;
                mem_wr    <= 1'b1;
                mem_addr  <= head_addr;
                mem_width <= head_width;
                mem_wdata <= head_data;
            end else if (mem_ack) begin
                mem_req <= 1'b0;
            end

            if (stall_req) begin
                wb_we <= 1'b0;
            end else begin
                wb_waddr <= in_waddr;
                if (in_mem_re && (l_state == L_DONE)) begin
                    wb_we    <= in_we;
                    wb_wdata <= ld_data;
                end else if (ld_fwd) begin
                    wb_we    <= in_we;
                    wb_wdata <= fwd_ext;
                end else if (in_fence) begin
                    wb_we    <= 1'b0;
                    wb_wdata <= in_wdata;
                end else begin
                    wb_we    <= in_we;
                    wb_wdata <= in_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ma_stbuf.sv
// Directed bench for ma_stbuf: reset, pass-through, drain, forwarding,
// conflicts, full buffer, load misses, fence and mid-operation reset.
module tb_ma_stbuf;
    import ma_stbuf_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        in_we, in_mem_we, in_mem_re, in_fence;
    logic [4:0]  in_waddr;
    logic [31:0] in_wdata, in_addr, in_mem_wdata;
    logic [2:0]  in_width;
    logic        mem_req, mem_wr, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_width;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        stall_req;

    int checks = 0;
    int failures = 0;

    ma_stbuf #(.SB_DEPTH(4), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
        .in_mem_we(in_mem_we), .in_mem_re(in_mem_re), .in_fence(in_fence),
        .in_width(in_width), .in_addr(in_addr), .in_mem_wdata(in_mem_wdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_width(mem_width), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in;
        in_we = 0; in_waddr = 0; in_wdata = 0;
        in_mem_we = 0; in_mem_re = 0; in_fence = 0;
        in_width = F3_W; in_addr = 0; in_mem_wdata = 0;
    endtask

    task automatic op_store(input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
        idle_in;
        in_mem_we = 1; in_width = w; in_addr = a; in_mem_wdata = d;
    endtask

    task automatic op_load(input logic [2:0] w, input logic [31:0] a, input logic [4:0] rd);
        idle_in;
        in_mem_re = 1; in_width = w; in_addr = a; in_we = 1; in_waddr = rd;
    endtask

    // Acks every write the DUT presents until the buffer is empty (bounded).
    task automatic drain_all;
        idle_in;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dut.u_fifo.count == 0 && !mem_req) break;
            mem_ack = mem_req && mem_wr;
            step;
            mem_ack = 0;
        end
        checks++;
        if (dut.u_fifo.count !== 3'd0 || mem_req !== 1'b0)
            $display("FAIL drain_all: count=%0d mem_req=%b want 0/0", dut.u_fifo.count, mem_req);
        if (dut.u_fifo.count !== 3'd0 || mem_req !== 1'b0) failures++;
    endtask

    task automatic test_reset;
        rst = 1; rdy = 1; mem_ack = 0; mem_rdata = 0; idle_in;
        step; step;
        rst = 0; #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (wb_we !== 1'b0 || wb_wdata !== 32'h0) begin failures++; $display("FAIL reset_wb: got %b/%h want 0/0", wb_we, wb_wdata); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        checks++; if (dut.u_fifo.count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", dut.u_fifo.count); end
    endtask

    task automatic test_passthrough;
        idle_in; in_we = 1; in_waddr = 5'd9; in_wdata = 32'hCAFEF00D; #1;
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL pass_stall: got %b want 0", stall_req); end
        step; idle_in;
        checks++; if (wb_we !== 1'b1 || wb_waddr !== 5'd9 || wb_wdata !== 32'hCAFEF00D) begin
            failures++; $display("FAIL pass_wb: got %b/%0d/%h want 1/9/cafef00d", wb_we, wb_waddr, wb_wdata); end
    endtask

    task automatic test_store_drain;
        op_store(F3_W, 32'h1000, 32'hDEADBEEF); #1;
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL st_stall: got %b want 0", stall_req); end
        step; idle_in; #1;
        checks++; if (dut.u_fifo.count !== 3'd1 || wb_we !== 1'b0) begin failures++; $display("FAIL st_count: got %0d/%b want 1/0", dut.u_fifo.count, wb_we); end
        step;
        checks++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h1000 || mem_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL st_req: got %b/%b/%h/%h want 1/1/1000/deadbeef", mem_req, mem_wr, mem_addr, mem_wdata); end
        mem_ack = 1; step; mem_ack = 0;
        checks++; if (dut.u_fifo.count !== 3'd0 || mem_req !== 1'b0) begin failures++; $display("FAIL st_ack: got %0d/%b want 0/0", dut.u_fifo.count, mem_req); end
    endtask

    task automatic test_forward;
        op_store(F3_W, 32'h2000, 32'h8899AABB); step;
        op_load(F3_B, 32'h2001, 5'd5); #1;
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL fwd_stall: got %b want 0", stall_req); end
        step; idle_in;
        checks++; if (wb_we !== 1'b1 || wb_waddr !== 5'd5 || wb_wdata !== 32'hFFFFFFAA) begin
            failures++; $display("FAIL fwd_wb: got %b/%0d/%h want 1/5/ffffffaa", wb_we, wb_waddr, wb_wdata); end
        checks++; if (mem_req === 1'b1 && mem_wr !== 1'b1) begin failures++; $display("FAIL fwd_noread: got wr=%b want 1", mem_wr); end
        drain_all;
    endtask

    task automatic test_conflict;
        op_store(F3_B, 32'h3002, 32'h55); step;
        op_load(F3_W, 32'h3000, 5'd7); #1;
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL cf_stall: got %b want 1", stall_req); end
        step; #1;
        checks++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h3002 || mem_wdata !== 32'h55 || stall_req !== 1'b1) begin
            failures++; $display("FAIL cf_drain: got %b/%b/%h/%h/%b want 1/1/3002/55/1", mem_req, mem_wr, mem_addr, mem_wdata, stall_req); end
        mem_ack = 1; step; mem_ack = 0; #1;
        checks++; if (stall_req !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL cf_after_drain: got %b/%b want 1/0", stall_req, mem_req); end
        step;
        checks++; if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h3000 || mem_width !== F3_W) begin
            failures++; $display("FAIL cf_read: got %b/%b/%h/%b want 1/0/3000/010", mem_req, mem_wr, mem_addr, mem_width); end
        mem_ack = 1; mem_rdata = 32'h12345678; step; mem_ack = 0; #1;
        checks++; if (stall_req !== 1'b0 || wb_we !== 1'b0) begin failures++; $display("FAIL cf_done: got %b/%b want 0/0", stall_req, wb_we); end
        step; idle_in;
        checks++; if (wb_we !== 1'b1 || wb_waddr !== 5'd7 || wb_wdata !== 32'h12345678) begin
            failures++; $display("FAIL cf_wb: got %b/%0d/%h want 1/7/12345678", wb_we, wb_waddr, wb_wdata); end
    endtask

    task automatic test_full;
        for (int i = 0; i < 4; i++) begin
            op_store(F3_W, 32'h5000 + 32'(4 * i), 32'hA0 + 32'(i)); #1;
            checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL full_fill%0d: got %b want 0", i, stall_req); end
            step;
        end
        op_store(F3_W, 32'h5010, 32'hA4); #1;
        checks++; if (stall_req !== 1'b1 || dut.u_fifo.count !== 3'd4) begin failures++; $display("FAIL full_stall: got %b/%0d want 1/4", stall_req, dut.u_fifo.count); end
        step; #1;
        checks++; if (stall_req !== 1'b1 || mem_addr !== 32'h5000) begin failures++; $display("FAIL full_hold: got %b/%h want 1/5000", stall_req, mem_addr); end
        mem_ack = 1; #1;
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL full_ack_stall: got %b want 1", stall_req); end
        step; mem_ack = 0; #1;
        checks++; if (stall_req !== 1'b0 || dut.u_fifo.count !== 3'd3) begin failures++; $display("FAIL full_release: got %b/%0d want 0/3", stall_req, dut.u_fifo.count); end
        step; idle_in; #1;
        checks++; if (dut.u_fifo.count !== 3'd4 || mem_req !== 1'b1 || mem_addr !== 32'h5004) begin
            failures++; $display("FAIL full_enq5: got %0d/%b/%h want 4/1/5004", dut.u_fifo.count, mem_req, mem_addr); end
        drain_all;
    endtask

    task automatic test_load_miss(input logic [2:0] w, input logic [31:0] exp);
        int stalls = 0;
        int rc = 0;
        op_load(w, 32'h4000, 5'd3);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!stall_req) break;
            stalls++;
            if (mem_req && !mem_wr) rc++;
            if (rc == 1 && mem_req) begin
                checks++;
                if (mem_addr !== 32'h4000 || mem_width !== w) begin
                    failures++; $display("FAIL miss_req: got %h/%b want 4000/%b", mem_addr, mem_width, w); end
            end
            mem_ack = (rc == 3); mem_rdata = 32'h0000F00D;
            step; mem_ack = 0;
        end
        checks++; if (stalls != 4) begin failures++; $display("FAIL miss_stall_cycles: got %0d want 4", stalls); end
        step; idle_in;
        checks++; if (wb_we !== 1'b1 || wb_waddr !== 5'd3 || wb_wdata !== exp) begin
            failures++; $display("FAIL miss_wb: got %b/%0d/%h want 1/3/%h", wb_we, wb_waddr, wb_wdata, exp); end
    endtask

    task automatic test_fence;
        int acks = 0;
        int stalls = 0;
        op_store(F3_W, 32'h6000, 32'h11); step;
        op_store(F3_W, 32'h6004, 32'h22); step;
        idle_in; in_fence = 1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!stall_req) break;
            stalls++;
            mem_ack = mem_req && mem_wr;
            if (mem_ack) acks++;
            step; mem_ack = 0;
        end
        checks++; if (acks != 2 || stalls < 2 || dut.u_fifo.count !== 3'd0) begin
            failures++; $display("FAIL fence_drain: got acks=%0d stalls=%0d count=%0d want 2/>=2/0", acks, stalls, dut.u_fifo.count); end
        step; idle_in;
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL fence_bubble: got %b want 0", wb_we); end
    endtask

    task automatic test_reset_mid;
        op_store(F3_W, 32'h7000, 32'h77); step;
        idle_in; step;
        checks++; if (mem_req !== 1'b1 || mem_wr !== 1'b1) begin failures++; $display("FAIL rstmid_busy: got %b/%b want 1/1", mem_req, mem_wr); end
        rst = 1; step; rst = 0; #1;
        checks++; if (mem_req !== 1'b0 || dut.u_fifo.count !== 3'd0 || wb_we !== 1'b0) begin
            failures++; $display("FAIL rstmid_clear: got %b/%0d/%b want 0/0/0", mem_req, dut.u_fifo.count, wb_we); end
        step; step;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_noreq: got %b want 0", mem_req); end
    endtask

    task automatic test_rdy_freeze;
        rdy = 0; op_store(F3_W, 32'h8000, 32'h99); step;
        checks++; if (dut.u_fifo.count !== 3'd0 || mem_req !== 1'b0) begin failures++; $display("FAIL rdy_freeze: got %0d/%b want 0/0", dut.u_fifo.count, mem_req); end
        rdy = 1; step; idle_in; #1;
        checks++; if (dut.u_fifo.count !== 3'd1) begin failures++; $display("FAIL rdy_resume: got %0d want 1", dut.u_fifo.count); end
        drain_all;
    endtask

    initial begin
        test_reset;
        test_passthrough;
        test_store_drain;
        test_forward;
        test_conflict;
        test_full;
        test_load_miss(F3_HU, 32'h0000F00D);
        test_load_miss(F3_H, 32'hFFFFF00D);
        test_fence;
        test_reset_mid;
        test_rdy_freeze;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
